addressing_tiles: RTL and testbench
===================================

ADDRESSING_TILES -- requirements
Module: addressing_tiles

Interface
REQ-001 The block SHALL expose these parameters (name, default, meaning):
- NUM_TILES, 4, number of side-by-side tiles (1..8)
- TILE_W, 240, tile width in pixels
- TILE_H, 320, tile height in lines
- X0, 8, hcount of the first pixel of tile 0
- Y0, 200, vcount of the first line of every tile
- PITCH, 256, hcount distance between tile origins; PITCH >= TILE_W
- ADDR_W, 17, address width; 2**ADDR_W >= TILE_W*TILE_H
REQ-002 Ports (name, direction, width, meaning):
- clk_in  input  1  pixel clock
- rst_in  input  1  reset, asynchronous, active-high
- hcount_in  input  11  horizontal pixel counter
- vcount_in  input  10  vertical line counter
- mode_in  input  2*NUM_TILES  per-tile scan mode; tile k uses bits [2k+1:2k]
- addr_out  output  ADDR_W*NUM_TILES  per-tile read address; tile k uses slice k
- valid_out  output  NUM_TILES  one-hot: tile k currently addressed
- tile_idx_out  output  max(1,$clog2(NUM_TILES))  index of active tile
- frame_start_out  output  1  one-cycle pulse at frame start
REQ-003 The block SHALL use one clock (clk_in); reset is asynchronous and active-high (rst_in).

Function
REQ-004 Tile k window: X0+k*PITCH <= hcount_in < X0+k*PITCH+TILE_W and Y0 <= vcount_in < Y0+TILE_H.
REQ-005 Inside window k: col = hcount_in-(X0+k*PITCH), row = vcount_in-Y0, L = TILE_W*TILE_H-1.
REQ-006 Address for active mode m of tile k:
- 00 raster: row*TILE_W+col
- 01 reversed: L-(row*TILE_W+col)
- 10 horizontal mirror: row*TILE_W+(TILE_W-1-col)
- 11 vertical flip: (TILE_H-1-row)*TILE_W+col
REQ-007 Latency SHALL be exactly 1 cycle: outputs registered at edge N reflect hcount_in/vcount_in sampled at edge N.
REQ-008 At most one valid_out bit SHALL be high; valid_out SHALL be 0 in gaps between tiles and outside the vertical band.
REQ-009 tile_idx_out SHALL equal the active tile index when valid_out!=0 and SHALL hold its last value otherwise.
REQ-010 addr_out slice k SHALL hold its last value while tile k is inactive.
REQ-011 Per-tile mode SHALL come from a shadow register loaded from mode_in only when hcount_in==0 and vcount_in==0; changes to mode_in mid-frame SHALL take effect next frame.
REQ-012 frame_start_out SHALL pulse high for one cycle, registered with the shadow load in REQ-011.
REQ-013 Address arithmetic SHALL be unsigned in ADDR_W bits with no wrap for legal parameters; illegal parameters (PITCH<TILE_W, ADDR_W too small) SHALL be rejected at elaboration.
REQ-014 hcount_in/vcount_in values beyond the last tile or screen SHALL produce valid_out=0 and no address change.

Reset
REQ-015 While rst_in is high, all outputs and shadow mode registers SHALL be 0, independent of clk_in.
REQ-016 After rst_in falls mid-frame, the block SHALL address in mode 00 for all tiles until the next frame start, producing correct addresses from the first cycle inside any window.

Verification
REQ-017 Defaults, modes all 00, raster sweep: (h=8,v=200) -> next cycle valid_out=0001, addr slice0=0; (h=1015,v=519) -> valid_out=1000, slice3=76799.
REQ-018 Mode 01 on tile 1 loaded at frame start: (h=264,v=200) -> slice1=76799; (h=503,v=519) -> slice1=0.
REQ-019 Modes 10 tile 2, 11 tile 0: (h=520,v=200) -> slice2=239; (h=8,v=200) -> slice0=76560.
REQ-020 Gap/hold: (h=250,v=300) -> valid_out=0000, tile_idx_out and all slices unchanged from (h=247,v=300).
REQ-021 mode_in changed at (h=100,v=300): addresses unchanged until (h=0,v=0) pulses frame_start_out, then new mode applies.
REQ-022 rst_in asserted asynchronously at (h=400,v=300): outputs 0 immediately; released, then (h=520,v=201) -> slice2=240 under mode 00.

Source files
------------

// File: rtl/addressing_tiles.sv
// Per-tile read address generator for NUM_TILES side-by-side tiles sharing one vertical band.
// Scan modes are shadowed at frame start; all outputs are registered one cycle after the counters.
module addressing_tiles #(
    parameter int NUM_TILES = 4,
    parameter int TILE_W    = 240,
    parameter int TILE_H    = 320,
    parameter int X0        = 8,
    parameter int Y0        = 200,
    parameter int PITCH     = 256,
    parameter int ADDR_W    = 17
) (
    input  logic                                           clk_in,
    input  logic                                           rst_in,
    input  logic [10:0]                                    hcount_in,
    input  logic [9:0]                                     vcount_in,
    input  logic [2*NUM_TILES-1:0]                         mode_in,
    output logic [ADDR_W*NUM_TILES-1:0]                    addr_out,
    output logic [NUM_TILES-1:0]                           valid_out,
    output logic [(NUM_TILES > 1 ? $clog2(NUM_TILES) : 1)-1:0] tile_idx_out,
    output logic                                           frame_start_out
);

    localparam int    IDX_W = (NUM_TILES > 1) ? $clog2(NUM_TILES) : 1;
    localparam longint AREA = longint'(TILE_W) * longint'(TILE_H);

    localparam logic [ADDR_W-1:0] TW   = ADDR_W'(TILE_W);
    localparam logic [ADDR_W-1:0] TWM1 = ADDR_W'(TILE_W - 1);
    localparam logic [ADDR_W-1:0] THM1 = ADDR_W'(TILE_H - 1);
    localparam logic [ADDR_W-1:0] LAST = ADDR_W'(AREA - 1);

    if (NUM_TILES < 1 || NUM_TILES > 8) begin : g_bad_num_tiles
        $error("addressing_tiles: NUM_TILES must be 1..8");
    end
    if (PITCH < TILE_W) begin : g_bad_pitch
        $error("addressing_tiles: PITCH must be >= TILE_W");
    end
    if ((longint'(1) << ADDR_W) < AREA) begin : g_bad_addr_w
        $error("addressing_tiles: ADDR_W too small for TILE_W*TILE_H");
    end

    logic [2*NUM_TILES-1:0] mode_q;
    logic [NUM_TILES-1:0]   hit;
    logic [IDX_W-1:0]       hit_idx;
    logic                   frame_start;
    logic                   in_v;
    logic [ADDR_W-1:0]      row;

    assign frame_start = (hcount_in == 11'd0) && (vcount_in == 10'd0);
    assign in_v = (32'(vcount_in) >= Y0) && (32'(vcount_in) < Y0 + TILE_H);
    assign row  = ADDR_W'(32'(vcount_in) - Y0);

    for (genvar k = 0; k < NUM_TILES; k++) begin : g_tile
        localparam int ORG = X0 + k * PITCH;

        logic              in_h;
        logic [ADDR_W-1:0] col;
        logic [ADDR_W-1:0] addr_nxt;
        logic [ADDR_W-1:0] addr_q;

        assign in_h   = (32'(hcount_in) >= ORG) && (32'(hcount_in) < ORG + TILE_W);
        assign hit[k] = in_h && in_v;
        assign col    = ADDR_W'(32'(hcount_in) - ORG);

        always_comb begin
            addr_nxt = row * TW + col;
            case (mode_q[2*k +: 2])
                2'b01:   addr_nxt = LAST - (row * TW + col);
                2'b10:   addr_nxt = row * TW + (TWM1 - col);
                2'b11:   addr_nxt = (THM1 - row) * TW + col;
                default: addr_nxt = row * TW + col;
            endcase
        end

        // Slice only moves while its own tile is addressed; otherwise it holds.
        always_ff @(posedge clk_in or posedge rst_in) begin
            if (rst_in) begin
                addr_q <= '0;
            end else if (hit[k]) begin
                addr_q <= addr_nxt;
            end
        end

        assign addr_out[k*ADDR_W +: ADDR_W] = addr_q;
    end

    // Windows never overlap, so at most one hit bit is set.
    always_comb begin
        hit_idx = '0;
        for (int k = 0; k < NUM_TILES; k++) begin
            if (hit[k]) begin
                hit_idx = IDX_W'(k);
            end
        end
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            mode_q          <= '0;
            valid_out       <= '0;
            tile_idx_out    <= '0;
            frame_start_out <= 1'b0;
        end else begin
            valid_out       <= hit;
            frame_start_out <= frame_start;
            if (frame_start) begin
                mode_q <= mode_in;
            end
            if (|hit) begin
                tile_idx_out <= hit_idx;
            end
        end
    end

endmodule

// File: tb/tb_addressing_tiles.sv
// Directed-vector bench for addressing_tiles at default parameters (4 tiles, 240x320, pitch 256).
module tb_addressing_tiles;

    localparam int AW = 17;

    logic            clk_in = 1'b0;
    logic            rst_in;
    logic [10:0]     hcount_in;
    logic [9:0]      vcount_in;
    logic [7:0]      mode_in;
    logic [4*AW-1:0] addr_out;
    logic [3:0]      valid_out;
    logic [1:0]      tile_idx_out;
    logic            frame_start_out;

    int n_tests = 0;
    int n_fail  = 0;

    addressing_tiles dut (
        .clk_in          (clk_in),
        .rst_in          (rst_in),
        .hcount_in       (hcount_in),
        .vcount_in       (vcount_in),
        .mode_in         (mode_in),
        .addr_out        (addr_out),
        .valid_out       (valid_out),
        .tile_idx_out    (tile_idx_out),
        .frame_start_out (frame_start_out)
    );

    always #5 clk_in = ~clk_in;

    function automatic logic [AW-1:0] slice(input int k);
        return addr_out[k*AW +: AW];
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic apply(input int h, input int v);
        @(negedge clk_in);
        hcount_in = 11'(h);
        vcount_in = 10'(v);
        @(posedge clk_in);
        #1;
    endtask

    initial begin
        rst_in    = 1'b1;
        hcount_in = '0;
        vcount_in = '0;
        mode_in   = '0;
        #12;
        check("rst_valid", 32'(valid_out), 0);
        check("rst_idx", 32'(tile_idx_out), 0);
        check("rst_fs", 32'(frame_start_out), 0);
        check("rst_addr", 32'(|addr_out), 0);
        @(negedge clk_in);
        rst_in = 1'b0;

        // raster sweep, all modes 00
        apply(0, 0);
        check("fs_pulse", 32'(frame_start_out), 1);
        apply(8, 200);
        check("fs_clear", 32'(frame_start_out), 0);
        check("r_valid0", 32'(valid_out), 32'b0001);
        check("r_slice0", 32'(slice(0)), 0);
        check("r_idx0", 32'(tile_idx_out), 0);
        apply(1015, 519);
        check("r_valid3", 32'(valid_out), 32'b1000);
        check("r_slice3", 32'(slice(3)), 76799);
        check("r_idx3", 32'(tile_idx_out), 3);
        apply(1100, 100);
        check("oob_valid", 32'(valid_out), 0);
        check("oob_idx_hold", 32'(tile_idx_out), 3);
        check("oob_slice3_hold", 32'(slice(3)), 76799);

        // tile0=11, tile1=01, tile2=10, tile3=00
        mode_in = 8'b00_10_01_11;
        apply(0, 0);
        check("fs_pulse2", 32'(frame_start_out), 1);
        apply(264, 200);
        check("m01_first", 32'(slice(1)), 76799);
        apply(503, 519);
        check("m01_last", 32'(slice(1)), 0);
        check("m01_idx", 32'(tile_idx_out), 1);
        apply(520, 200);
        check("m10_first", 32'(slice(2)), 239);
        apply(8, 200);
        check("m11_first", 32'(slice(0)), 76560);

        // gap hold
        apply(247, 300);
        check("g_slice0", 32'(slice(0)), 52799);
        check("g_valid_pre", 32'(valid_out), 32'b0001);
        apply(250, 300);
        check("g_valid", 32'(valid_out), 0);
        check("g_idx", 32'(tile_idx_out), 0);
        check("g_slice0_hold", 32'(slice(0)), 52799);
        check("g_slice1_hold", 32'(slice(1)), 0);
        check("g_slice2_hold", 32'(slice(2)), 239);
        check("g_slice3_hold", 32'(slice(3)), 76799);

        // mid-frame mode change waits for frame start
        mode_in = 8'b00_00_00_00;
        apply(100, 300);
        apply(520, 201);
        check("mc_old_mode", 32'(slice(2)), 479);
        apply(0, 0);
        check("mc_fs", 32'(frame_start_out), 1);
        apply(520, 201);
        check("mc_new_mode", 32'(slice(2)), 240);

        // async reset mid-frame
        mode_in = 8'b00_10_01_11;
        apply(0, 0);
        apply(400, 300);
        check("ar_pre_slice1", 32'(slice(1)), 52663);
        check("ar_pre_valid", 32'(valid_out), 32'b0010);
        rst_in = 1'b1;
        #2;
        check("ar_valid", 32'(valid_out), 0);
        check("ar_addr", 32'(|addr_out), 0);
        check("ar_idx", 32'(tile_idx_out), 0);
        @(negedge clk_in);
        rst_in = 1'b0;
        apply(520, 201);
        check("ar_mode00", 32'(slice(2)), 240);
        check("ar_valid2", 32'(valid_out), 32'b0100);
        check("ar_idx2", 32'(tile_idx_out), 2);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
